gpio_regs: RTL and testbench

- GPIO register file sitting directly downstream of the GPIO address decoder in the SoC memory-mapped I/O path.
- Consumes the decoder's write enables (WE1, WE2) and read select (RdSel).
- Holds two output registers and synchronizes two external input ports.
- Tracks sticky change flags on the inputs, raises an interrupt line, and returns the selected word on the read bus.

---
 rtl/gpio_regs.sv | 153 +++++++++++++++
 tb/tb_gpio_regs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_regs.sv
// GPIO register file: two CPU-writable output registers, two synchronized
// input ports with sticky change flags, an interrupt line and a read mux.
// Change detection is held off for ARM_CYCLES edges after reset so inputs
// flushing through the zeroed synchronizers do not raise false events.
module gpio_regs #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ARM_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WE1,
    input  logic             WE2,
    input  logic [1:0]       RdSel,
    input  logic             RE,
    input  logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] gpI1,
    input  logic [WIDTH-1:0] gpI2,
    output logic [WIDTH-1:0] gpO1,
    output logic [WIDTH-1:0] gpO2,
    output logic [WIDTH-1:0] RD,
    output logic [1:0]       chg,
    output logic             irq
);

    typedef enum logic {
        StDisarmed,
        StArmed
    } arm_state_e;

    localparam logic [2:0] ArmLast = 3'(ARM_CYCLES - 1);
    localparam logic [2:0] ArmFull = 3'(ARM_CYCLES);

    logic [WIDTH-1:0] r_gpo1;
    logic [WIDTH-1:0] r_gpo2;

    logic [WIDTH-1:0] r_s1_1;
    logic [WIDTH-1:0] r_s2_1;
    logic [WIDTH-1:0] r_h_1;
    logic [WIDTH-1:0] r_s1_2;
    logic [WIDTH-1:0] r_s2_2;
    logic [WIDTH-1:0] r_h_2;

    logic [1:0]       r_chg;
    arm_state_e       r_arm_state;
    logic [2:0]       r_arm_cnt;

    logic             w_armed;
    logic [1:0]       w_diff;
    logic [1:0]       w_set;
    logic [1:0]       w_clr;
    logic [WIDTH-1:0] w_rd;

    // Output registers: each strobe loads WD; both strobes together load both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpo1 <= '0;
            r_gpo2 <= '0;
        end else begin
            if (WE1) begin
                r_gpo1 <= WD;
            end
            if (WE2) begin
                r_gpo2 <= WD;
            end
        end
    end

    // Two-flop synchronizers plus a history stage holding the previous s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_1 <= '0;
            r_s2_1 <= '0;
            r_h_1  <= '0;
            r_s1_2 <= '0;
            r_s2_2 <= '0;
            r_h_2  <= '0;
        end else begin
            r_s1_1 <= gpI1;
            r_s2_1 <= r_s1_1;
            r_h_1  <= r_s2_1;
            r_s1_2 <= gpI2;
            r_s2_2 <= r_s1_2;
            r_h_2  <= r_s2_2;
        end
    end

    // Arm FSM: count edges after reset, then stay armed until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_state <= StDisarmed;
            r_arm_cnt   <= '0;
        end else begin
            unique case (r_arm_state)
                StDisarmed: begin
                    if (r_arm_cnt == ArmLast) begin
                        r_arm_cnt   <= ArmFull;
                        r_arm_state <= StArmed;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 3'd1;
                    end
                end
                StArmed: begin
                    r_arm_cnt   <= ArmFull;
                    r_arm_state <= StArmed;
                end
                default: begin
                    r_arm_cnt   <= '0;
                    r_arm_state <= StDisarmed;
                end
            endcase
        end
    end

    // Per-port change detection and read-acknowledge decode.
    always_comb begin
        w_armed  = (r_arm_state == StArmed);
        w_diff   = '0;
        w_diff[0] = (r_s2_1 != r_h_1);
        w_diff[1] = (r_s2_2 != r_h_2);
        w_set    = {2{w_armed}} & w_diff;
        w_clr    = '0;
        w_clr[0] = RE && (RdSel == 2'b00);
        w_clr[1] = RE && (RdSel == 2'b01);
    end

    // Sticky flags: a set in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chg <= '0;
        end else begin
            r_chg <= w_set | (r_chg & ~w_clr);
        end
    end

    // Read mux straight off the register contents, no extra latency.
    always_comb begin
        w_rd = '0;
        unique case (RdSel)
            2'b00:   w_rd = r_s2_1;
            2'b01:   w_rd = r_s2_2;
            2'b10:   w_rd = r_gpo1;
            2'b11:   w_rd = r_gpo2;
            default: w_rd = '0;
        endcase
    end

    assign gpO1 = r_gpo1;
    assign gpO2 = r_gpo2;
    assign RD   = w_rd;
    assign chg  = r_chg;
    assign irq  = |r_chg;

endmodule

// File: tb/tb_gpio_regs.sv
// Bench for gpio_regs: directed scenarios with literal expectations, then a
// randomized phase, all compared every cycle against a behavioural model.
module tb_gpio_regs;

    localparam int W   = 32;
    localparam int ARM = 3;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         WE1   = 1'b0;
    logic         WE2   = 1'b0;
    logic         RE    = 1'b0;
    logic [1:0]   RdSel = 2'b00;
    logic [W-1:0] WD    = '0;
    logic [W-1:0] gpI1  = 32'hFFFF_0000;
    logic [W-1:0] gpI2  = '0;
    logic [W-1:0] gpO1;
    logic [W-1:0] gpO2;
    logic [W-1:0] RD;
    logic [1:0]   chg;
    logic         irq;

    int checks = 0;
    int errors = 0;

    gpio_regs #(
        .WIDTH      (W),
        .ARM_CYCLES (ARM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .WE1   (WE1),
        .WE2   (WE2),
        .RdSel (RdSel),
        .RE    (RE),
        .WD    (WD),
        .gpI1  (gpI1),
        .gpI2  (gpI2),
        .gpO1  (gpO1),
        .gpO2  (gpO2),
        .RD    (RD),
        .chg   (chg),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-port history of input samples, [0] = taken at the latest edge.
    // The readable synchronized value is the sample from one edge earlier; a
    // change is seen when that differs from the sample two edges earlier.
    logic [W-1:0] m_hist1 [3];
    logic [W-1:0] m_hist2 [3];
    int           m_edges;
    logic [1:0]   m_chg;
    logic [W-1:0] m_o1;
    logic [W-1:0] m_o2;

    function automatic logic [W-1:0] m_rd(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_hist1[1];
            2'd1:    return m_hist2[1];
            2'd2:    return m_o1;
            default: return m_o2;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist1[i] = '0;
            m_hist2[i] = '0;
        end
        m_edges = 0;
        m_chg   = '0;
        m_o1    = '0;
        m_o2    = '0;
    endtask

    task automatic model_edge();
        logic [1:0] s_set;
        logic [1:0] s_clr;
        s_set[0] = (m_edges >= ARM) && (m_hist1[1] != m_hist1[2]);
        s_set[1] = (m_edges >= ARM) && (m_hist2[1] != m_hist2[2]);
        s_clr[0] = RE && (RdSel == 2'd0);
        s_clr[1] = RE && (RdSel == 2'd1);
        for (int k = 0; k < 2; k++) begin
            if (s_set[k]) m_chg[k] = 1'b1;
            else if (s_clr[k]) m_chg[k] = 1'b0;
        end
        if (WE1) m_o1 = WD;
        if (WE2) m_o2 = WD;
        m_hist1[2] = m_hist1[1];
        m_hist1[1] = m_hist1[0];
        m_hist1[0] = gpI1;
        m_hist2[2] = m_hist2[1];
        m_hist2[1] = m_hist2[0];
        m_hist2[0] = gpI2;
        m_edges++;
    endtask

    // Compare process: update the model on each edge or reset, check 2 units later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
            #2;
            check("gpO1", gpO1, m_o1);
            check("gpO2", gpO2, m_o2);
            check("RD", RD, m_rd(RdSel));
            check("chg", W'(chg), W'(m_chg));
            check("irq", W'(irq), W'(|m_chg));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        // Reset with gpI1 already nonzero.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rd_after_release", RD, 32'h0);
        tick();
        check("rd_edge1", RD, 32'h0);
        tick();
        check("rd_edge2", RD, 32'hFFFF_0000);
        repeat (8) tick();
        check("idle_chg", W'(chg), 32'h0);
        check("idle_irq", W'(irq), 32'h0);

        // Write path.
        WE1 = 1'b1;
        WD  = 32'h1234_5678;
        tick();
        WE1 = 1'b0;
        WE2 = 1'b1;
        WD  = 32'hDEAD_BEEF;
        tick();
        WE2 = 1'b0;
        WD  = 32'h0;
        check("wr_gpo1", gpO1, 32'h1234_5678);
        check("wr_gpo2", gpO2, 32'hDEAD_BEEF);
        RdSel = 2'b10;
        #1 check("rd_sel10", RD, 32'h1234_5678);
        RdSel = 2'b11;
        #1 check("rd_sel11", RD, 32'hDEAD_BEEF);
        RdSel = 2'b00;
        #1 check("rd_sel00", RD, 32'hFFFF_0000);

        // Change-detect latency on port 2.
        gpI2 = 32'h0000_0001;
        tick();
        RdSel = 2'b01;
        #1 check("lat_rd_n", RD, 32'h0);
        tick();
        check("lat_rd_n1", RD, 32'h1);
        check("lat_chg_n1", W'(chg), 32'h0);
        tick();
        check("lat_chg_n2", W'(chg), 32'h2);
        check("lat_irq_n2", W'(irq), 32'h1);
        check("model_chg_n2", W'(m_chg), 32'h2);

        // Set chg1 as well.
        gpI1 = 32'h0000_0001;
        repeat (3) tick();
        check("both_chg", W'(chg), 32'h3);

        // Read-acknowledge.
        RE    = 1'b1;
        RdSel = 2'b00;
        tick();
        RE = 1'b0;
        check("ack1_chg", W'(chg), 32'h2);
        check("ack1_irq", W'(irq), 32'h1);
        RE    = 1'b1;
        RdSel = 2'b11;
        tick();
        RE = 1'b0;
        check("ack_o2_chg", W'(chg), 32'h2);
        RE    = 1'b1;
        RdSel = 2'b01;
        tick();
        RE = 1'b0;
        check("ack2_chg", W'(chg), 32'h0);
        check("ack2_irq", W'(irq), 32'h0);
        check("model_ack2", W'(m_chg), 32'h0);

        // Clear coinciding with the set edge: set wins.
        gpI1 = 32'h0000_0002;
        tick();
        tick();
        RE    = 1'b1;
        RdSel = 2'b00;
        tick();
        RE = 1'b0;
        check("setclr_chg", W'(chg), 32'h1);
        check("model_setclr", W'(m_chg), 32'h1);

        // Reset mid-operation.
        WE1 = 1'b1;
        WD  = 32'hA5A5_A5A5;
        tick();
        WE1 = 1'b0;
        check("pre_rst_gpo1", gpO1, 32'hA5A5_A5A5);
        check("pre_rst_chg", W'(chg), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_gpo1", gpO1, 32'h0);
        check("rst_chg", W'(chg), 32'h0);
        check("rst_irq", W'(irq), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < ARM + 2; i++) begin
            tick();
            check("rearm_chg", W'(chg), 32'h0);
        end

        // Randomized traffic, including occasional resets.
        repeat (600) begin
            WE1   = ($urandom % 4) == 0;
            WE2   = ($urandom % 4) == 0;
            WD    = $urandom;
            RdSel = 2'($urandom % 4);
            RE    = ($urandom % 3) == 0;
            if (($urandom % 5) == 0) gpI1 = gpI1 ^ (W'(1) << ($urandom % W));
            if (($urandom % 5) == 0) gpI2 = gpI2 ^ (W'(1) << ($urandom % W));
            if (($urandom % 80) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
